// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target with 7-bit address match and pointer-addressed register file
module i2c_slave_regfile #(
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  localparam int        PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl,
  inout  wire           sda,
  input  logic [6:0]    my_addr,
  input  logic [PW-1:0] rf_rd_addr,
  output logic [7:0]    rf_rd_data,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  localparam int NREG = 1 << PW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [7:0]    regs [NREG];
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [6:0]    shift, shift_n;
  logic [6:0]    tx, tx_n;
  logic [PW-1:0] ptr, ptr_n, ptr_inc;
  logic          rw, rw_n, ack_ph, ack_ph_n, sda_oe, sda_oe_n, busy_n;
  logic          wr_strobe_n;
  logic [PW-1:0] wr_addr_n;
  logic [7:0]    wr_data_n;
  logic [7:0]    byte_in, rd_byte;
  logic          byte_done;

  // Sync chains reset to the idle-high bus level so reset release creates no edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign byte_in   = {shift, sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);
  assign rd_byte   = regs[ptr];
  assign ptr_inc   = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

  assign sda        = sda_oe ? 1'b0 : 1'bz;
  assign rf_rd_data = regs[rf_rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    tx_n        = tx;
    ptr_n       = ptr;
    rw_n        = rw;
    ack_ph_n    = ack_ph;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    wr_strobe_n = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      if (scl_rise && (state == ADDR || state == PTR || state == WDATA)) begin
        shift_n   = byte_in[6:0];
        bit_cnt_n = bit_cnt + 3'd1;
      end
      case (state)
        ADDR: if (byte_done) begin
          if (byte_in[7:1] == my_addr) begin
            state_n  = ADDR_ACK;
            rw_n     = byte_in[0];
            busy_n   = 1'b1;
            ack_ph_n = 1'b0;
          end else begin
            state_n = WAIT_STOP;
            busy_n  = 1'b0;
          end
        end
        PTR: if (byte_done) begin
          if ({1'b0, byte_in} < 9'(DEPTH)) begin
            state_n  = PTR_ACK;
            ptr_n    = byte_in[PW-1:0];
            ack_ph_n = 1'b0;
          end else begin
            state_n = WAIT_STOP;
            busy_n  = 1'b0;
          end
        end
        WDATA: if (byte_done) begin
          wr_strobe_n = 1'b1;
          wr_addr_n   = ptr;
          wr_data_n   = byte_in;
          ptr_n       = ptr_inc;
          state_n     = WDATA_ACK;
          ack_ph_n    = 1'b0;
        end
        // First fall pulls SDA for the ACK, second fall ends the 9th clock
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!ack_ph) begin
            sda_oe_n = 1'b1;
            ack_ph_n = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (state == ADDR_ACK && rw) begin
              state_n  = RDATA;
              tx_n     = rd_byte[6:0];
              sda_oe_n = ~rd_byte[7];
            end else if (state == ADDR_ACK) begin
              state_n = PTR;
            end else begin
              state_n = WDATA;
            end
          end
        end
        RDATA: if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            sda_oe_n = 1'b0;
            state_n  = RACK;
            ptr_n    = ptr_inc;
            ack_ph_n = 1'b0;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            sda_oe_n  = ~tx[6];
            tx_n      = {tx[5:0], 1'b0};
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ack_ph_n = 1'b1;
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && ack_ph) begin
            state_n   = RDATA;
            bit_cnt_n = '0;
            tx_n      = rd_byte[6:0];
            sda_oe_n  = ~rd_byte[7];
          end
        end
        WAIT_STOP: sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_ph    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      tx        <= tx_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      ack_ph    <= ack_ph_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_strobe <= wr_strobe_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
    end
  end

  // Register update shares its edge with wr_strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RESET_VAL;
    end else if (wr_strobe_n) begin
      regs[wr_addr_n] <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - bench for i2c_slave_regfile
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int Q = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  logic sel12 = 1'b0;
  wire  sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  logic [6:0] addr16, addr12;
  assign addr16 = sel12 ? 7'h55 : 7'h42;
  assign addr12 = sel12 ? 7'h42 : 7'h55;

  logic [3:0] rd_addr16 = '0, rd_addr12 = '0;
  logic [7:0] rd_data16, rd_data12, wr_data16, wr_data12;
  logic [3:0] wr_addr16, wr_addr12;
  logic       wr_strobe16, wr_strobe12, busy16, busy12;

  i2c_slave_regfile #(.DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda_bus), .my_addr(addr16),
    .rf_rd_addr(rd_addr16), .rf_rd_data(rd_data16), .wr_strobe(wr_strobe16),
    .wr_addr(wr_addr16), .wr_data(wr_data16), .busy(busy16));

  i2c_slave_regfile #(.DEPTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda_bus), .my_addr(addr12),
    .rf_rd_addr(rd_addr12), .rf_rd_data(rd_data12), .wr_strobe(wr_strobe12),
    .wr_addr(wr_addr12), .wr_data(wr_data12), .busy(busy12));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] wlog [1024];
  int wcnt = 0;
  int wcnt12 = 0;

  always @(negedge clk) begin
    if (wr_strobe16) begin
      wlog[wcnt % 1024] <= {wr_addr16, wr_data16};
      wcnt <= wcnt + 1;
    end
    if (wr_strobe12) wcnt12 <= wcnt12 + 1;
  end

  logic [7:0] m16 [16];
  int mptr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_low = ~b; #Q;
    scl = 1'b1; #Q;
    r = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b0; #Q;
    repeat (4) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(~mack, r);
  endtask

  task automatic sweep16(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr16 = 4'(i); #1;
      check(tag, rd_data16, m16[i]);
    end
  endtask

  // Write transaction: target address a, pointer p, then n data bytes
  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                          input logic [7:0] d0, d1, d2, d3);
    logic [7:0] d [4];
    logic [11:0] ew [4];
    int ne = 0;
    int base = wcnt;
    logic ack, matched, ok;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    matched = (a == 7'h42);
    i2c_start;
    write_byte({a, 1'b0}, ack);
    check("addr_ack", ack, matched);
    check("busy_after_addr", busy16, matched);
    write_byte(p, ack);
    ok = matched && (p < 8'd16);
    check("ptr_ack", ack, ok);
    if (ok) mptr = int'(p);
    for (int k = 0; k < n; k++) begin
      write_byte(d[k], ack);
      check("data_ack", ack, ok);
      if (ok) begin
        ew[ne] = {4'(mptr), d[k]};
        ne++;
        m16[mptr] = d[k];
        mptr = (mptr + 1) % 16;
      end
    end
    i2c_stop;
    check("busy_after_stop", busy16, 1'b0);
    check("wr_count", wcnt - base, ne);
    for (int k = 0; k < ne && k < wcnt - base; k++)
      check("wr_strobe_addr_data", wlog[(base + k) % 1024], ew[k]);
  endtask

  // Pointer set, repeated START, then n reads; last byte is NACKed
  task automatic do_read(input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] got;
    i2c_start;
    write_byte(8'h84, ack);
    check("rd_addr_w_ack", ack, 1'b1);
    write_byte(p, ack);
    check("rd_ptr_ack", ack, 1'b1);
    mptr = int'(p);
    i2c_start;
    write_byte(8'h85, ack);
    check("rd_addr_r_ack", ack, 1'b1);
    for (int k = 0; k < n; k++) begin
      read_byte(k < n - 1, got);
      check("read_data", got, m16[mptr]);
      mptr = (mptr + 1) % 16;
    end
    check("sda_z_after_nack", sda_bus, 1'b1);
    i2c_stop;
    check("busy_after_read", busy16, 1'b0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic ack, r;
    logic [7:0] got;
    int base;
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_sda", sda_bus, 1'b1);
    check("rst_busy", busy16, 1'b0);
    check("rst_strobe", wr_strobe16, 1'b0);
    check("rst_wr_addr", wr_addr16, 4'h0);
    check("rst_wr_data", wr_data16, 8'h00);
    sweep16("rst_regs");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_write(7'h42, 8'h03, 2, 8'hA5, 8'h5A, 8'h00, 8'h00);
    rd_addr16 = 4'h3; #1; check("t1_reg3", rd_data16, 8'hA5);
    rd_addr16 = 4'h4; #1; check("t1_reg4", rd_data16, 8'h5A);

    do_read(8'h03, 2);

    do_write(7'h50, 8'h11, 0, 8'h00, 8'h00, 8'h00, 8'h00);

    do_write(7'h42, 8'h0F, 3, 8'h11, 8'h22, 8'h33, 8'h00);
    sweep16("t4_regs");

    sel12 = 1'b1;
    base = wcnt;
    i2c_start;
    write_byte(8'h84, ack); check("t5_addr_ack", ack, 1'b1);
    write_byte(8'h0C, ack); check("t5_ptr_nack", ack, 1'b0);
    write_byte(8'h77, ack); check("t5_data_nack", ack, 1'b0);
    i2c_stop;
    check("t5_no_write12", wcnt12, 0);
    check("t5_no_write16", wcnt - base, 0);
    check("t5_busy12", busy12, 1'b0);
    rd_addr12 = 4'hC; #1; check("t5_reg12_c", rd_data12, 8'h00);
    rd_addr12 = 4'h0; #1; check("t5_reg12_0", rd_data12, 8'h00);
    sel12 = 1'b0;

    base = wcnt;
    i2c_start;
    write_byte(8'h84, ack); check("t6_addr_ack", ack, 1'b1);
    write_byte(8'h05, ack); check("t6_ptr_ack", ack, 1'b1);
    mptr = 5;
    for (int i = 0; i < 4; i++) bit_xfer(1'b0, r);
    i2c_stop;
    check("t6_partial_no_write", wcnt - base, 0);
    sweep16("t6_regs");

    i2c_start;
    write_byte(8'h84, ack); check("t6r_addr_ack", ack, 1'b1);
    write_byte(8'h04, ack); check("t6r_ptr_ack", ack, 1'b1);
    i2c_start;
    write_byte(8'h85, ack); check("t6r_rd_ack", ack, 1'b1);
    got = 8'h00;
    for (int i = 7; i >= 1; i--) bit_xfer(1'b1, got[i]);
    check("t6r_bits7_1", got[7:1], m16[4][7:1]);
    repeat (2) @(negedge clk);
    check("t6r_bit0_driven", sda_bus, m16[4][0]);
    rst_n = 1'b0;
    #1;
    check("t6r_sda_async_release", sda_bus, 1'b1);
    m_low = 1'b0;
    scl = 1'b1;
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;
    mptr = 0;
    repeat (3) @(negedge clk);
    check("t6r_busy", busy16, 1'b0);
    check("t6r_wr_addr", wr_addr16, 4'h0);
    check("t6r_wr_data", wr_data16, 8'h00);
    sweep16("t6r_regs_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int t = 0; t < 24; t++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        do_write(7'h42, 8'($urandom_range(0, 19)), int'($urandom_range(0, 4)),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end else if (kind == 1) begin
        do_read(8'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
      end else begin
        do_write(7'h42 ^ (7'd1 << $urandom_range(0, 6)), 8'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 8'h00, 8'h00);
      end
    end
    sweep16("final_regs");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
